// File: rtl/alu_op_sequencer.sv
// Handshake wrapper around a combinational ALU: registers a command, captures
// the ALU result and flags, and keeps a chain carry for multi-word arithmetic.
module alu_op_sequencer #(
    parameter int BUS_WIDTH = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_a,
    input  logic [BUS_WIDTH-1:0] in_b,
    input  logic [3:0]           in_opcode,
    input  logic                 in_use_carry,
    input  logic                 in_clear_carry,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_y,
    output logic [4:0]           out_flags,
    output logic                 carry_flag,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;

    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_INC  = 4'd4;
    localparam logic [3:0] OP_DEC  = 4'd5;

    assign in_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            alu_carry_in <= 1'b0;
            out_valid    <= 1'b0;
            out_y        <= '0;
            out_flags    <= '0;
            carry_flag   <= 1'b0;
            err_count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a        <= in_a;
                        alu_b        <= in_b;
                        alu_opcode   <= in_opcode;
                        alu_carry_in <= in_use_carry & ~in_clear_carry
                                        & carry_flag;
                        if (in_clear_carry)
                            carry_flag <= 1'b0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_y     <= alu_y;
                    out_flags <= {alu_invalid_op, alu_parity, alu_zero,
                                  alu_borrow, alu_carry_out};
                    out_valid <= 1'b1;
                    // Chain carry follows only the carry/borrow producing ops
                    if (alu_opcode == OP_ADDC || alu_opcode == OP_INC)
                        carry_flag <= alu_carry_out;
                    else if (alu_opcode == OP_SUB || alu_opcode == OP_DEC)
                        carry_flag <= alu_borrow;
                    if (alu_invalid_op && err_count != '1)
                        err_count <= err_count + ERR_CNT_W'(1);
                    state <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
